// File: rtl/dsp_mac_pkg.sv
// Shared types and sizing helpers for the MAC resolve stage.
package dsp_mac_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      RES_LO = 2'd1,
      RES_HI = 2'd2,
      OUT    = 2'd3
   } state_t;

   // Accumulator width: full product plus guard bits for burst growth.
   function automatic int acc_w(input int n, input int m, input int guard);
      return n + m + guard;
   endfunction

   // Split point of the two-cycle resolve adder (low half width).
   function automatic int lo_w(input int acc);
      return acc / 2;
   endfunction

   localparam int DEF_ACC_W = acc_w(16, 16, 8);
   localparam int LO_W      = lo_w(DEF_ACC_W);

endpackage

// File: rtl/dsp_mac_resolve_csa32.sv
// One row of 3:2 compressors: a+b+c == sum + 2*carry (bitwise full adders).
module csa32 #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/dsp_mac_resolve.sv
// MAC back end for the Dadda multiplier: resolves each carry-save product,
// folds it into a carry-save accumulator, and resolves the burst total with a
// two-cycle split adder before presenting it on a valid/ready output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ACCUM  | accepting beats, folding products into acc_s/acc_c
// RES_LO | low half of acc_s + 2*acc_c registered with its carry-out
// RES_HI | high half added with that carry, result and count latched
// OUT    | result held on out_data/out_count until downstream accepts
module dsp_mac_resolve
   import dsp_mac_pkg::*;
#(
   parameter int N      = 16,
   parameter int M      = 16,
   parameter int SIGNED = 1,
   parameter int GUARD  = 8,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N+M-1:0]         in_op1,
   input  logic [N+M-1:0]         in_op2,
   input  logic                   in_first,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N+M+GUARD-1:0]   out_data,
   output logic [CNT_W-1:0]       out_count
);

   localparam int P_W    = N + M;
   localparam int ACC_W  = acc_w(N, M, GUARD);
   localparam int RLO_W  = lo_w(ACC_W);
   localparam int RHI_W  = ACC_W - RLO_W;

   state_t              state_q;
   state_t              state_d;
   logic                run_q;

   logic                p_valid;
   logic                p_first;
   logic                p_last;
   logic [P_W-1:0]      p_reg;

   logic [ACC_W-1:0]    acc_s;
   logic [ACC_W-1:0]    acc_c;
   logic [ACC_W-1:0]    acc_c_sh;
   logic [CNT_W-1:0]    cnt;
   logic                burst_open;

   logic [RLO_W-1:0]    lo_sum;
   logic                lo_carry;

   logic                accept;
   logic                fold;
   logic                load;
   logic                sign_bit;
   logic [ACC_W-1:0]    ext;
   logic [ACC_W-1:0]    csa_sum;
   logic [ACC_W-1:0]    csa_carry;
   logic [CNT_W-1:0]    cnt_inc;
   logic [RHI_W-1:0]    hi_sum;
   logic                done;

   // A held last beat blocks intake so that only one burst is ever in flight.
   assign in_ready  = run_q && (state_q == ACCUM) && !(p_valid && p_last);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == OUT);
   assign done      = out_valid && out_ready;

   // p_reg is already a true product modulo 2^P_W, so extending it is safe.
   assign sign_bit  = (SIGNED != 0) && p_reg[P_W-1];
   assign ext       = {{GUARD{sign_bit}}, p_reg};
   assign acc_c_sh  = acc_c << 1;
   assign fold      = p_valid && (state_q == ACCUM);
   assign load      = p_first || !burst_open;
   assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
   assign hi_sum    = acc_s[ACC_W-1:RLO_W] + acc_c_sh[ACC_W-1:RLO_W]
                    + {{(RHI_W-1){1'b0}}, lo_carry};

   csa32 #(.W(ACC_W)) u_fold (
      .a     (acc_s),
      .b     (acc_c_sh),
      .c     (ext),
      .sum   (csa_sum),
      .carry (csa_carry)
   );

   // Holds in_ready low for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   // Stage P: collapse the carry-save pair, dropping the overflow bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_valid <= 1'b0;
         p_first <= 1'b0;
         p_last  <= 1'b0;
         p_reg   <= '0;
      end else begin
         p_valid <= accept;
         if (accept) begin
            p_reg   <= in_op1 + in_op2;
            p_first <= in_first;
            p_last  <= in_last;
         end
      end
   end

   // Stage A: load or fold the extended product into the redundant accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_s      <= '0;
         acc_c      <= '0;
         cnt        <= '0;
         burst_open <= 1'b0;
      end else if (fold) begin
         burst_open <= 1'b1;
         if (load) begin
            acc_s <= ext;
            acc_c <= '0;
            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            acc_s <= csa_sum;
            acc_c <= csa_carry;
            cnt   <= cnt_inc;
         end
      end else if (done) begin
         burst_open <= 1'b0;
      end
   end

   // Two-cycle carry-propagate resolve; out_data/out_count change only in RES_HI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_sum    <= '0;
         lo_carry  <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (state_q == RES_LO) begin
         {lo_carry, lo_sum} <= {1'b0, acc_s[RLO_W-1:0]} + {1'b0, acc_c_sh[RLO_W-1:0]};
      end else if (state_q == RES_HI) begin
         out_data  <= {hi_sum, lo_sum};
         out_count <= cnt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM:  if (fold && p_last) state_d = RES_LO;
         RES_LO: state_d = RES_HI;
         RES_HI: state_d = OUT;
         OUT:    if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

endmodule

// File: tb/tb_dsp_mac_resolve.sv
// Directed bench: a signed and an unsigned instance share all stimulus.
module tb_dsp_mac_resolve;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_op1 = '0;
   logic [31:0] in_op2 = '0;
   logic        in_first = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready_s, in_ready_u;
   logic        out_valid_s, out_valid_u;
   logic [39:0] out_data_s, out_data_u;
   logic [7:0]  out_count_s, out_count_u;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dsp_mac_resolve #(.N(16), .M(16), .SIGNED(1), .GUARD(8), .CNT_W(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_op1(in_op1), .in_op2(in_op2), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_count(out_count_s)
   );

   dsp_mac_resolve #(.N(16), .M(16), .SIGNED(0), .GUARD(8), .CNT_W(8)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
      .in_op1(in_op1), .in_op2(in_op2), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
      .out_count(out_count_u)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l);
      int k;
      k = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op1 = a; in_op2 = b; in_first = f; in_last = l;
      while (!in_ready_s && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk("accept_timeout", in_ready_s, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (out_valid_s) break;
      end
   endtask

   task automatic result(input string tag, input logic [39:0] es, input logic [39:0] eu,
                         input logic [7:0] ec);
      int lat;
      wait_out(lat);
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_uvalid"}, out_valid_u, 1);
      chk({tag, "_data"}, out_data_s, es);
      chk({tag, "_udata"}, out_data_u, eu);
      chk({tag, "_count"}, out_count_s, ec);
      chk({tag, "_ucount"}, out_count_u, ec);
      chk({tag, "_inrdy_out"}, in_ready_s, 0);
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_ovld_after"}, out_valid_s, 0);
      chk({tag, "_rdy_after"}, in_ready_s, 1);
      chk({tag, "_urdy_after"}, in_ready_u, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready_s, 0);
      chk("rst_out_valid", out_valid_s, 0);
      chk("rst_out_data", out_data_s, 0);
      chk("rst_out_count", out_count_s, 0);
      rst_n = 1'b1;
      chk("rel_in_ready_0", in_ready_s, 0);
      @(negedge clk);
      chk("rel_in_ready_1", in_ready_s, 1);

      // Single beat 100 + -145 = -45
      beat(32'd100, 32'hFFFF_FF6F, 1'b1, 1'b1);
      result("single", 40'hFF_FFFF_FFD3, 40'h00_FFFF_FFD3, 8'd1);
      handshake("single");

      // Burst of three: -45, -100, 21 -> -124
      beat(32'd1000,      32'hFFFF_FBEB, 1'b1, 1'b0);
      beat(32'hFFFF_FFF9, 32'hFFFF_FFA3, 1'b0, 1'b0);
      beat(32'd30,        32'hFFFF_FFF7, 1'b0, 1'b1);
      result("burst3", 40'hFF_FFFF_FF84, 40'h01_FFFF_FF84, 8'd3);
      handshake("burst3");

      // Redundant pair whose words overflow individually: product 3
      beat(32'hFFFF_FFF0, 32'h0000_0013, 1'b1, 1'b1);
      result("wrap3", 40'd3, 40'd3, 8'd1);
      handshake("wrap3");

      // All-ones product: -1 signed, 2^32-1 unsigned
      beat(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
      result("ones", 40'hFF_FFFF_FFFF, 40'h00_FFFF_FFFF, 8'd1);
      handshake("ones");

      // Growth into guard bits: 2 x 0x7FFFFFFF + 1
      beat(32'h7FFF_FFFF, 32'h0,         1'b1, 1'b0);
      beat(32'h3FFF_FFFF, 32'h4000_0000, 1'b0, 1'b0);
      beat(32'd1,         32'h0,         1'b0, 1'b1);
      result("guard", 40'h00_FFFF_FFFF, 40'h00_FFFF_FFFF, 8'd3);

      // Backpressure: result held, intake blocked while a beat waits
      @(negedge clk);
      in_valid = 1'b1; in_op1 = 32'd5; in_op2 = 32'd6; in_first = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data", out_data_s, 40'h00_FFFF_FFFF);
         chk("bp_count", out_count_s, 3);
         chk("bp_valid", out_valid_s, 1);
         chk("bp_in_ready", in_ready_s, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_ovld_after", out_valid_s, 0);
      chk("bp_rdy_after", in_ready_s, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      result("bp_next", 40'd11, 40'd11, 8'd1);
      handshake("bp_next");

      // in_first mid-burst restarts the accumulation
      beat(32'd10, 32'd0, 1'b1, 1'b0);
      beat(32'd20, 32'd0, 1'b1, 1'b1);
      result("restart", 40'd20, 40'd20, 8'd1);
      handshake("restart");

      // Beat without in_first while idle is a first beat; out_ready already high
      out_ready = 1'b1;
      beat(32'd4, 32'd0, 1'b0, 1'b1);
      result("idle", 40'd4, 40'd4, 8'd1);
      @(negedge clk);
      chk("idle_ovld_after", out_valid_s, 0);
      chk("idle_rdy_after", in_ready_s, 1);
      out_ready = 1'b0;

      // Count saturation: 260 beats of 1
      for (int i = 0; i < 260; i++)
         beat(32'd1, 32'd0, (i == 0), (i == 259));
      result("sat", 40'd260, 40'd260, 8'd255);
      handshake("sat");

      // Reset while in RES_HI: nothing emitted, then a clean single beat
      beat(32'd50, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", out_valid_s, 0);
      chk("abort_in_ready", in_ready_s, 0);
      chk("abort_data", out_data_s, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_rdy_rel", in_ready_s, 1);
      @(negedge clk);
      chk("abort_no_stale", out_valid_s, 0);
      beat(32'd7, 32'd0, 1'b1, 1'b1);
      result("post_rst", 40'd7, 40'd7, 8'd1);
      handshake("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
